// File: rtl/sram_req_ctrl.sv
// Request-side controller for a single-port, registered-read SRAM macro.
// Issues requests to the SRAM pins and returns read data in order through a small response FIFO.
module sram_req_ctrl #(
  parameter int unsigned A_WIDTH   = 8,
  parameter int unsigned D_WIDTH   = 32,
  parameter int unsigned RSP_DEPTH = 2,
  parameter int unsigned CNT_W     = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic               req_we,
  input  logic [A_WIDTH-1:0] req_addr,
  input  logic [D_WIDTH-1:0] req_wdata,
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic [D_WIDTH-1:0] rsp_rdata,
  output logic               sram_nWE,
  output logic [A_WIDTH-1:0] sram_addr,
  output logic [D_WIDTH-1:0] sram_din,
  input  logic [D_WIDTH-1:0] sram_dout,
  output logic [CNT_W-1:0]   wr_count,
  output logic [CNT_W-1:0]   rd_count
);

  localparam int unsigned PW = $clog2(RSP_DEPTH);
  localparam int unsigned CW = PW + 1;

  logic [D_WIDTH-1:0] mem_q [RSP_DEPTH];
  logic [PW-1:0]      wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]      fifo_cnt_q;
  logic               rd_pend_q;
  logic [CNT_W-1:0]   wr_count_q, rd_count_q;

  logic               accept, pop, push;
  logic [CW:0]        credit_used;

  assign rsp_valid = ~rst & (fifo_cnt_q != '0);
  assign pop       = rsp_valid & rsp_ready;
  assign push      = rd_pend_q;

  // Entries committed after the next edge; a new read needs one free slot beyond that.
  assign credit_used = {1'b0, fifo_cnt_q} + {{CW{1'b0}}, rd_pend_q} - {{CW{1'b0}}, pop};
  assign req_ready   = ~rst & (credit_used < (CW+1)'(RSP_DEPTH));
  assign accept      = req_valid & req_ready;

  assign sram_nWE  = ~(accept & req_we);
  assign sram_addr = req_addr;
  assign sram_din  = req_wdata;

  assign rsp_rdata = mem_q[rd_ptr_q];
  assign wr_count  = wr_count_q;
  assign rd_count  = rd_count_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      fifo_cnt_q <= '0;
      rd_pend_q  <= 1'b0;
      wr_count_q <= '0;
      rd_count_q <= '0;
    end else begin
      rd_pend_q <= accept & ~req_we;
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      if (push & ~pop) begin
        fifo_cnt_q <= fifo_cnt_q + 1'b1;
      end else if (~push & pop) begin
        fifo_cnt_q <= fifo_cnt_q - 1'b1;
      end
      if (accept & req_we & ~(&wr_count_q))  wr_count_q <= wr_count_q + 1'b1;
      if (accept & ~req_we & ~(&rd_count_q)) rd_count_q <= rd_count_q + 1'b1;
    end
  end

  // Storage is left untouched by reset; the cleared count marks it invalid.
  always_ff @(posedge clk) begin
    if (!rst && push) mem_q[wr_ptr_q] <= sram_dout;
  end

endmodule
